ysyx_23060208_pc_ctrl: RTL
==========================

// Module: ysyx_23060208_pc_ctrl
// PURPOSE
//   Sequences the PC register: decides when it updates (pc_wen) and to what (next_pc).
//   Issues the instruction-fetch request for the current PC and hands the fetched
//   instruction to decode. Selects the next PC from: sequential, branch/jump, trap
//   vector or mret return. Sits between the PC register, the IFU and the EXU.
// PARAMETERS
//   DATA_WIDTH   32             PC / instruction / address width
//   RESET_VECTOR 32'h8000_0000  first fetch address (PC register resets to RESET_VECTOR-4)
// PORTS
//   clk            in   1   clock
//   rst            in   1   reset, synchronous, active-high
//   pc             in   32  current PC register value
//   pc_wen         out  1   PC register write enable (one-cycle pulse)
//   next_pc        out  32  PC register write data
//   ifu_req_valid  out  1   fetch request valid
//   ifu_req_addr   out  32  fetch address (= pc)
//   ifu_req_ready  in   1   IFU accepts request
//   ifu_resp_valid in   1   fetch response valid
//   ifu_resp_inst  in   32  fetched instruction
//   ifu_resp_err   in   1   fetch access fault
//   inst_valid     out  1   instruction presented to decode/EXU
//   inst / inst_pc out  32  instruction and its PC
//   exu_done       in   1   EXU finished inst; redirect inputs below valid this cycle
//   br_taken       in   1   branch/jump taken;  br_target in 32 target
//   ecall, mret    in   1   environment call / trap return
//   ebreak         in   1   halt simulation
//   mtvec, mepc    in   32  trap vector / return address
//   trap_valid     out  1   one-cycle pulse: CSR unit writes mepc/mcause
//   trap_cause     out  4   0 = inst addr misaligned, 1 = inst access fault, 11 = ecall
//   trap_epc       out  32  PC of trapping instruction
//   halted         out  1   set after ebreak, sticky until rst
// BEHAVIOUR
//   - States: UPDATE, FETCH, WAIT, EXEC, HALT. rst -> UPDATE with next_pc_r=RESET_VECTOR.
//   - Reset values: pc_wen=0, ifu_req_valid=0, inst_valid=0, trap_valid=0, halted=0,
//     next_pc=RESET_VECTOR, trap_cause=0, trap_epc=0.
//   - UPDATE: pc_wen=1 for exactly one cycle with next_pc_r -> FETCH.
//   - FETCH: ifu_req_valid=1, ifu_req_addr=pc, held stable until ifu_req_ready -> WAIT.
//   - WAIT: on ifu_resp_valid: err=0 -> latch inst -> EXEC; err=1 -> trap (cause 1,
//     epc=pc), next_pc_r=mtvec -> UPDATE (EXEC skipped).
//   - EXEC: inst_valid=1 until exu_done. On exu_done select next_pc_r, priority:
//     ebreak -> HALT (no pc_wen); ecall -> mtvec, trap cause 11;
//     br_taken & br_target[1:0]!=0 -> mtvec, trap cause 0, epc=pc;
//     mret -> mepc; br_taken -> br_target; else pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
//     Then -> UPDATE. trap_valid pulses the cycle after exu_done (in UPDATE).
//   - Minimum 4 cycles/instruction (UPDATE, FETCH, WAIT, EXEC), each state >=1 cycle.
//   - ifu_resp_valid outside WAIT is ignored; exu_done outside EXEC is ignored.
//   - Simultaneous ecall+mret or ecall+br_taken: ecall wins.
//   - rst in any state (incl. HALT, mid-fetch) -> UPDATE next cycle; outstanding
//     fetch response dropped.
//   - HALT: all outputs idle, halted=1, pc frozen.
// CONFIGURATION
//   PC_CTRL_PERF_EN defined: 64-bit outputs perf_cycle (increments every non-rst cycle
//     while not halted) and perf_instret (increments on each accepted exu_done,
//     excluding ebreak); both reset to 0.
//   Undefined: perf ports present, tied to 0; no counter flops.
// STRUCTURE
//   Package ysyx_23060208_pkg: state encoding, trap cause codes (CAUSE_MISALIGN=0,
//   CAUSE_FETCH_FAULT=1, CAUSE_ECALL=11), RESET_VECTOR.
//   Sub-module ysyx_23060208_next_pc_sel: combinational priority mux producing
//   next_pc, trap flag, cause.
// TESTING
//   1 rst 2 cycles, IFU always ready, 1-cycle resp -> pc_wen pulse next_pc=0x8000_0000,
//     fetch addr 0x8000_0000, then 0x8000_0004 after exu_done.
//   2 EXEC at pc=0x8000_0010, br_taken=1 target=0x8000_0100 -> next fetch 0x8000_0100.
//   3 ecall at pc=0x8000_0020, mtvec=0x8000_0400 -> trap_valid, cause 11,
//     epc 0x8000_0020, fetch 0x8000_0400; then mret, mepc=0x8000_0024 -> fetch 0x8000_0024.
//   4 br_taken target=0x8000_0102 -> trap cause 0, epc=pc, fetch mtvec.
//   5 ifu_req_ready low 5 cycles, ifu_resp_err=1 -> req/addr stable 5 cycles;
//     trap cause 1, no inst_valid.
//   6 ebreak -> halted=1, no further pc_wen/ifu_req_valid; rst in WAIT and HALT ->
//     restart at 0x8000_0000.

Source files
------------

// File: rtl/ysyx_23060208_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, trap cause codes
// and the default first fetch address.
package ysyx_23060208_pkg;

  typedef enum logic [2:0] {
    ST_UPDATE = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } pc_state_e;

  localparam logic [3:0]  CAUSE_MISALIGN    = 4'd0;
  localparam logic [3:0]  CAUSE_FETCH_FAULT = 4'd1;
  localparam logic [3:0]  CAUSE_ECALL       = 4'd11;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060208_next_pc_sel.sv
// Combinational redirect selection for a completed instruction.
// Priority: ecall, misaligned taken branch, mret, taken branch, sequential.
// ebreak is handled by the caller, which never commits a PC for it.
module ysyx_23060208_next_pc_sel
  import ysyx_23060208_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  br_taken,
  input  logic [DATA_WIDTH-1:0] br_target,
  input  logic                  ecall,
  input  logic                  mret,
  input  logic [DATA_WIDTH-1:0] mtvec,
  input  logic [DATA_WIDTH-1:0] mepc,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  trap,
  output logic [3:0]            cause
);

  // Priority mux; pc + 4 wraps naturally at the top of the address space
  always_comb begin
    next_pc = pc + DATA_WIDTH'(4);
    trap    = 1'b0;
    cause   = CAUSE_MISALIGN;
    if (ecall) begin
      next_pc = mtvec;
      trap    = 1'b1;
      cause   = CAUSE_ECALL;
    end else if (br_taken && (br_target[1:0] != 2'b00)) begin
      next_pc = mtvec;
      trap    = 1'b1;
      cause   = CAUSE_MISALIGN;
    end else if (mret) begin
      next_pc = mepc;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/ysyx_23060208_pc_ctrl.sv
// PC sequencer: UPDATE -> FETCH -> WAIT -> EXEC per instruction, with trap
// redirection and an ebreak halt state.
// Optional feature macro PC_CTRL_PERF_EN: enables 64-bit cycle / retired
// instruction counters; without it the perf ports are tied to zero.
module ysyx_23060208_pc_ctrl #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = ysyx_23060208_pkg::RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  pc_wen,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  ifu_req_valid,
  output logic [DATA_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_req_ready,
  input  logic                  ifu_resp_valid,
  input  logic [DATA_WIDTH-1:0] ifu_resp_inst,
  input  logic                  ifu_resp_err,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  exu_done,
  input  logic                  br_taken,
  input  logic [DATA_WIDTH-1:0] br_target,
  input  logic                  ecall,
  input  logic                  mret,
  input  logic                  ebreak,
  input  logic [DATA_WIDTH-1:0] mtvec,
  input  logic [DATA_WIDTH-1:0] mepc,
  output logic                  trap_valid,
  output logic [3:0]            trap_cause,
  output logic [DATA_WIDTH-1:0] trap_epc,
  output logic                  halted,
  output logic [63:0]           perf_cycle,
  output logic [63:0]           perf_instret
);
  import ysyx_23060208_pkg::*;

  pc_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] next_pc_r, trap_epc_r, inst_r, inst_pc_r;
  logic [DATA_WIDTH-1:0] sel_next_pc;
  logic                  sel_trap, trap_valid_r;
  logic [3:0]            sel_cause, trap_cause_r;
  logic                  fetch_ok, fetch_fault, retire, commit;

  assign fetch_ok    = (state_q == ST_WAIT) && ifu_resp_valid && !ifu_resp_err;
  assign fetch_fault = (state_q == ST_WAIT) && ifu_resp_valid &&  ifu_resp_err;
  assign retire      = (state_q == ST_EXEC) && exu_done;
  assign commit      = retire && !ebreak;

  ysyx_23060208_next_pc_sel #(.DATA_WIDTH(DATA_WIDTH)) u_sel (
    .pc        (inst_pc_r),
    .br_taken  (br_taken),
    .br_target (br_target),
    .ecall     (ecall),
    .mret      (mret),
    .mtvec     (mtvec),
    .mepc      (mepc),
    .next_pc   (sel_next_pc),
    .trap      (sel_trap),
    .cause     (sel_cause)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_UPDATE;
    else     state_q <= state_d;
  end

  // Next-state logic; a faulting fetch skips EXEC and goes straight to UPDATE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UPDATE: state_d = ST_FETCH;
      ST_FETCH:  if (ifu_req_ready) state_d = ST_WAIT;
      ST_WAIT:   if (ifu_resp_valid) state_d = ifu_resp_err ? ST_UPDATE : ST_EXEC;
      ST_EXEC:   if (exu_done) state_d = ebreak ? ST_HALT : ST_UPDATE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_UPDATE;
    endcase
  end

  // Redirect target and trap report, captured when leaving WAIT or EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc_r    <= RESET_VECTOR;
      trap_valid_r <= 1'b0;
      trap_cause_r <= CAUSE_MISALIGN;
      trap_epc_r   <= '0;
    end else begin
      trap_valid_r <= 1'b0;
      if (fetch_fault) begin
        next_pc_r    <= mtvec;
        trap_valid_r <= 1'b1;
        trap_cause_r <= CAUSE_FETCH_FAULT;
        trap_epc_r   <= pc;
      end
      if (commit) begin
        next_pc_r    <= sel_next_pc;
        trap_valid_r <= sel_trap;
        if (sel_trap) begin
          trap_cause_r <= sel_cause;
          trap_epc_r   <= inst_pc_r;
        end
      end
    end
  end

  // Fetched instruction and its PC; pure data, no reset needed
  always_ff @(posedge clk) begin
    if (fetch_ok) begin
      inst_r    <= ifu_resp_inst;
      inst_pc_r <= pc;
    end
  end

  assign pc_wen        = (state_q == ST_UPDATE) && !rst;
  assign next_pc       = next_pc_r;
  assign ifu_req_valid = (state_q == ST_FETCH) && !rst;
  assign ifu_req_addr  = pc;
  assign inst_valid    = (state_q == ST_EXEC) && !rst;
  assign inst          = inst_r;
  assign inst_pc       = inst_pc_r;
  assign trap_valid    = trap_valid_r;
  assign trap_cause    = trap_cause_r;
  assign trap_epc      = trap_epc_r;
  assign halted        = (state_q == ST_HALT) && !rst;

`ifdef PC_CTRL_PERF_EN
  logic [63:0] perf_cycle_r, perf_instret_r;

  // Cycle and retired-instruction counters; ebreak is not counted as retired
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycle_r   <= '0;
      perf_instret_r <= '0;
    end else begin
      if (state_q != ST_HALT) perf_cycle_r <= perf_cycle_r + 64'd1;
      if (commit)             perf_instret_r <= perf_instret_r + 64'd1;
    end
  end

  assign perf_cycle   = perf_cycle_r;
  assign perf_instret = perf_instret_r;
`else
  assign perf_cycle   = '0;
  assign perf_instret = '0;
`endif

endmodule
